// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle for the UART receiver: the serial line in,
// the recovered byte and the per-frame status pulses out.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 din;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 busy;

    // Drives the line and observes the receiver's results.
    modport master (
        output din,
        input  data,
        input  valid,
        input  frame_err,
        input  busy
    );

    // The receiver itself.
    modport slave (
        input  din,
        output data,
        output valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver.
// Line format: idle high, one start bit (0), DATA_BITS data bits MSB first,
// one stop bit (1), OVERSAMPLE clk cycles per bit.
// The asynchronous line goes through a two-flop synchroniser. A falling edge
// seen in IDLE starts a frame. The start bit is re-checked at mid-bit, each
// data bit and the stop bit are sampled mid-bit, and a good frame updates the
// data register with a one-cycle valid pulse. A bad stop bit gives a one-cycle
// frame_err pulse instead and leaves data untouched.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    uart_rx_if.slave rx
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_ZERO = {BW{1'b0}};
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    // Synchroniser and edge-detect history.
    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic din_s;
    logic start_edge_s;

    // FSM state and datapath registers.
    state_t               state_r;
    state_t               state_nxt;
    logic [CW-1:0]        cnt_r;
    logic [CW-1:0]        cnt_nxt;
    logic [BW-1:0]        bit_r;
    logic [BW-1:0]        bit_nxt;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_nxt;
    logic [DATA_BITS-1:0] data_r;
    logic [DATA_BITS-1:0] data_nxt;
    logic                 valid_r;
    logic                 valid_nxt;
    logic                 ferr_r;
    logic                 ferr_nxt;
    logic                 busy_r;
    logic                 busy_nxt;

    assign din_s        = sync2_r;
    // Only a high-to-low transition starts a frame; a line that is already
    // low (break, or a bad stop bit running on) never does.
    assign start_edge_s = (din_s == 1'b0) && (prev_r == 1'b1);

    // Two-flop synchroniser for the asynchronous line, plus the previous
    // synchronised sample for edge detection; all reset to the idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= rx.din;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // State and datapath register bank; everything visible outside is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            bit_r   <= BIT_ZERO;
            shift_r <= {DATA_BITS{1'b0}};
            data_r  <= {DATA_BITS{1'b0}};
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            bit_r   <= bit_nxt;
            shift_r <= shift_nxt;
            data_r  <= data_nxt;
            valid_r <= valid_nxt;
            ferr_r  <= ferr_nxt;
            busy_r  <= busy_nxt;
        end
    end

    // Next-state and next-datapath logic; the baud counter restarts at zero on
    // every state change so each phase measures from its own entry.
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        bit_nxt   = bit_r;
        shift_nxt = shift_r;
        data_nxt  = data_r;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;

        case (state_r)
            IDLE: begin
                cnt_nxt = CNT_ZERO;
                bit_nxt = BIT_ZERO;
                if (start_edge_s) begin
                    state_nxt = START;
                end else begin
                    state_nxt = IDLE;
                end
            end

            START: begin
                // Half a bit after the edge: still low means a real start bit.
                if (cnt_r == HALF_M1) begin
                    cnt_nxt = CNT_ZERO;
                    bit_nxt = BIT_ZERO;
                    if (din_s == 1'b0) begin
                        state_nxt = DATA;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end
            end

            DATA: begin
                // One full bit after the previous mid-bit sample.
                if (cnt_r == FULL_M1) begin
                    cnt_nxt   = CNT_ZERO;
                    shift_nxt = {shift_r[DATA_BITS-2:0], din_s};
                    if (bit_r == LAST_BIT) begin
                        bit_nxt   = BIT_ZERO;
                        state_nxt = STOP;
                    end else begin
                        bit_nxt   = bit_r + BIT_ONE;
                    end
                end else begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end
            end

            STOP: begin
                if (cnt_r == FULL_M1) begin
                    cnt_nxt   = CNT_ZERO;
                    state_nxt = IDLE;
                    if (din_s == 1'b1) begin
                        data_nxt  = shift_r;
                        valid_nxt = 1'b1;
                    end else begin
                        ferr_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = CNT_ZERO;
                bit_nxt   = BIT_ZERO;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    assign rx.data      = data_r;
    assign rx.valid     = valid_r;
    assign rx.frame_err = ferr_r;
    assign rx.busy      = busy_r;

endmodule
